ks_mem_responder: RTL
=====================

Name: ks_mem_responder

Overview:
- Memory-side responder for the K&S multicycle core.
- Accepts single fetch, load and store requests issued by the core's control FSM.
- Serves them from an internal word-addressed RAM after a fixed, configurable number of wait states, and returns a one-cycle response pulse.
- Sits between the datapath address/data buses and program/data storage; replaces the zero-latency RAM so the control unit can be exercised against real memory timing.

Parameters:
- ADDR_W, 5, word-address width; depth = 2**ADDR_W words.
- DATA_W, 16, data word width.
- WAIT_STATES, 1, idle cycles between accept and response; legal range 0..15.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_write  in  1  1 = store, 0 = fetch/load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  responder can accept this cycle.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; for stores, the pre-write contents.
- busy  out  1  request in flight (state is not IDLE).

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, on rst.
- Reset values while rst=1 and on the cycle after release: state=IDLE, req_ready=0 during rst then 1, rsp_valid=0, rsp_rdata=0, busy=0, wait counter=0. RAM contents are not reset.
- Accept: a request is accepted on any rising edge where req_valid && req_ready. At that edge addr, write and wdata are captured into holding registers. Request inputs are ignored at all other times.
- FSM states and transitions:
  - IDLE: req_ready=1. On accept, go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else go to ACCESS.
  - WAIT: req_ready=0, busy=1. Counter decrements; leave for ACCESS when the counter is 0.
  - ACCESS: req_ready=0, busy=1. At the ending edge: rsp_rdata <= mem[held addr], then if write, mem[held addr] <= held wdata (read-before-write). Go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, busy=1, req_ready=0. Go to IDLE.
- Latency: rsp_valid is high in cycle N+WAIT_STATES+2, where N is the accept cycle.
  - Minimum request spacing is WAIT_STATES+3 cycles.
  - No pipelining and no response backpressure; the core always consumes rsp_valid.
- rsp_rdata holds its value until the next ACCESS edge.
- Boundary conditions:
  - Request in the same cycle as rst: ignored.
  - rst in WAIT or ACCESS: the transaction is aborted. An uncommitted store is not written; a store whose ACCESS edge already occurred stays written.
  - req_valid held high through RESP: the next accept happens only in the following IDLE cycle.
  - Address wrap: none; every ADDR_W value is a legal location.
  - WAIT_STATES=0: WAIT is skipped entirely.

Optional Feature:
- Macro: KS_MEM_ACCESS_CNT_EN.
- When defined:
  - Adds output ports rd_count (16 bits) and wr_count (16 bits).
  - Each increments by 1 at the ACCESS edge of a completed read or write, respectively.
  - Saturates at 16'hFFFF. Cleared by rst.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- k_and_s_pkg gains:
  - mem_state_t enum (IDLE, WAIT, ACCESS, RESP).
  - Constants KS_MEM_ADDR_W=5, KS_MEM_DATA_W=16, KS_MEM_MAX_WAIT=15.
- One sub-module, ks_ram_array: synchronous single-port RAM with read-before-write, a registered read port, and no reset.
- The FSM, wait counter and holding registers stay in ks_mem_responder.

Test Plan:
- Reset with WAIT_STATES=1: hold rst 2 cycles → req_ready=0 during rst and 1 the cycle after, rsp_valid=0, busy=0.
- Write then read, WAIT_STATES=1:
  - Store addr=5, data=16'hBEEF at cycle N → rsp_valid at N+3, rsp_rdata = old contents.
  - Load addr=5 → rsp_valid 3 cycles after its accept, rsp_rdata=16'hBEEF.
- WAIT_STATES=0 and WAIT_STATES=15: load addr=0 → rsp_valid at N+2 and N+17 respectively; req_ready=0 throughout, busy=1.
- req_valid held high, addr=31 with 16'h1234 preloaded: accepts occur every WAIT_STATES+3 cycles, each rsp_rdata=16'h1234, rsp_valid never high two cycles in a row.
- Reset mid-operation: store addr=7, data=16'hAAAA, rst asserted in WAIT → subsequent load of addr=7 returns the original value, not 16'hAAAA.
- With KS_MEM_ACCESS_CNT_EN: 3 loads and 2 stores → rd_count=3, wr_count=2; rst clears both to 0.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S core memory side.
package k_and_s_pkg;

    localparam int unsigned KS_MEM_ADDR_W   = 5;
    localparam int unsigned KS_MEM_DATA_W   = 16;
    localparam int unsigned KS_MEM_MAX_WAIT = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } mem_state_t;

    // Saturating 16-bit increment for the access counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ks_ram_array.sv
// Single-port synchronous RAM, registered read, read-before-write, no reset.
module ks_ram_array #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read old contents and optionally overwrite on the same edge.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) begin
                mem[addr] <= wdata;
            end
        end
    end

endmodule

// File: rtl/ks_mem_responder.sv
// Memory responder for the K&S multicycle core: accepts one fetch/load/store,
// waits WAIT_STATES cycles, accesses the RAM and pulses rsp_valid for one cycle.
// Optional access counters are enabled with `define KS_MEM_ACCESS_CNT_EN.
import k_and_s_pkg::*;

module ks_mem_responder #(
    parameter int unsigned ADDR_W      = KS_MEM_ADDR_W,
    parameter int unsigned DATA_W      = KS_MEM_DATA_W,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef KS_MEM_ACCESS_CNT_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output logic              busy
);

    localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_state_t        state_q;
    logic [3:0]        wait_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic              rdata_vld_q;
    logic [DATA_W-1:0] ram_rdata;
    logic              mem_en;
    logic              mem_we;

    // A request seen while rst is high must not be taken.
    assign req_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign rsp_valid = rsp_valid_q;
    // RAM output register has no reset; mask it until the first access.
    assign rsp_rdata = rdata_vld_q ? ram_rdata : '0;

    // Gating with rst aborts an access whose ending edge coincides with reset.
    assign mem_en = (state_q == ACCESS) && !rst;
    assign mem_we = mem_en && write_q;

    // Control FSM, wait counter and request holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_vld_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        write_q <= req_write;
                        wdata_q <= req_wdata;
                        if (WAIT_STATES > 0) begin
                            state_q    <= WAIT;
                            wait_cnt_q <= WaitLoad;
                        end else begin
                            state_q <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= ACCESS;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ACCESS: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rdata_vld_q <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    ks_ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

`ifdef KS_MEM_ACCESS_CNT_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

    // Count completed accesses at the ACCESS edge, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else if (mem_en) begin
            if (write_q) begin
                wr_count_q <= sat_inc16(wr_count_q);
            end else begin
                rd_count_q <= sat_inc16(rd_count_q);
            end
        end
    end
`endif

endmodule
